// File: rtl/clocking_skew_if_if.sv
// Bus bundle for clocking_skew_if: sampled input bus plus prioritized drive strobes.
// collision_cnt exists only when CB_COLLISION_CNT_EN is defined.
interface clocking_skew_if_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sig1_input;
  logic [WIDTH-1:0] cb_sig1_input;
  logic             drv0_valid;
  logic [WIDTH-1:0] drv0_data;
  logic             drv1_valid;
  logic [WIDTH-1:0] drv1_data;
  logic [WIDTH-1:0] sig2_output;
`ifdef CB_COLLISION_CNT_EN
  logic [7:0]       collision_cnt;

  modport master (
    output sig1_input, drv0_valid, drv0_data, drv1_valid, drv1_data,
    input  cb_sig1_input, sig2_output, collision_cnt
  );
  modport slave (
    input  sig1_input, drv0_valid, drv0_data, drv1_valid, drv1_data,
    output cb_sig1_input, sig2_output, collision_cnt
  );
`else
  modport master (
    output sig1_input, drv0_valid, drv0_data, drv1_valid, drv1_data,
    input  cb_sig1_input, sig2_output
  );
  modport slave (
    input  sig1_input, drv0_valid, drv0_data, drv1_valid, drv1_data,
    output cb_sig1_input, sig2_output
  );
`endif
endinterface

// File: rtl/clocking_skew_if.sv
// Clocked signal boundary: IN_STAGES-deep input sampling, drive visible OUT_STAGES-1 edges after acceptance.
// No backpressure; every valid drive is accepted, drv1 beats drv0. CB_COLLISION_CNT_EN adds a saturating collision counter.
module clocking_skew_if #(
  parameter int WIDTH      = 8,
  parameter int IN_STAGES  = 1,
  parameter int OUT_STAGES = 1
) (
  input logic             clk,
  input logic             rst_n,
  clocking_skew_if_if.slave bus
);

  logic [WIDTH-1:0] in_q [IN_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IN_STAGES; i++) in_q[i] <= '0;
    end else begin
      in_q[0] <= bus.sig1_input;
      for (int i = 1; i < IN_STAGES; i++) in_q[i] <= in_q[i-1];
    end
  end

  assign bus.cb_sig1_input = in_q[IN_STAGES-1];

  logic             sel_vld;
  logic [WIDTH-1:0] sel_dat;
  logic             fin_vld;
  logic [WIDTH-1:0] fin_dat;

  always_comb begin
    sel_vld = 1'b0;
    sel_dat = '0;
    if (bus.drv1_valid) begin
      sel_vld = 1'b1;
      sel_dat = bus.drv1_data;
    end else if (bus.drv0_valid) begin
      sel_vld = 1'b1;
      sel_dat = bus.drv0_data;
    end
  end

  // The output register itself is the last stage, so only OUT_STAGES-1 flops sit in front of it.
  generate
    if (OUT_STAGES == 1) begin : g_direct
      assign fin_vld = sel_vld;
      assign fin_dat = sel_dat;
    end else begin : g_pipe
      logic [OUT_STAGES-2:0] pv;
      logic [WIDTH-1:0]      pd [OUT_STAGES-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pv <= '0;
          for (int i = 0; i < OUT_STAGES-1; i++) pd[i] <= '0;
        end else begin
          pv[0] <= sel_vld;
          pd[0] <= sel_dat;
          for (int i = 1; i < OUT_STAGES-1; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
          end
        end
      end

      assign fin_vld = pv[OUT_STAGES-2];
      assign fin_dat = pd[OUT_STAGES-2];
    end
  endgenerate

  logic [WIDTH-1:0] sig2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig2_q <= '0;
    end else if (fin_vld) begin
      sig2_q <= fin_dat;
    end
  end

  assign bus.sig2_output = sig2_q;

`ifdef CB_COLLISION_CNT_EN
  logic [7:0] coll_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_q <= 8'h00;
    end else if (bus.drv0_valid && bus.drv1_valid && coll_q != 8'hFF) begin
      coll_q <= coll_q + 8'h01;
    end
  end

  assign bus.collision_cnt = coll_q;
`endif

endmodule

// File: tb/tb_clocking_skew_if.sv
// Bench for clocking_skew_if: a 1/1-stage and a 2/3-stage instance share stimulus and are
// compared against a history-based reference model.
module tb_clocking_skew_if;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sig1 = 8'h00;
  logic       d0v = 1'b0, d1v = 1'b0;
  logic [7:0] d0d = 8'h00, d1d = 8'h00;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  clocking_skew_if_if #(.WIDTH(8)) ifa ();
  clocking_skew_if_if #(.WIDTH(8)) ifb ();

  assign ifa.sig1_input = sig1;
  assign ifa.drv0_valid = d0v;
  assign ifa.drv0_data  = d0d;
  assign ifa.drv1_valid = d1v;
  assign ifa.drv1_data  = d1d;
  assign ifb.sig1_input = sig1;
  assign ifb.drv0_valid = d0v;
  assign ifb.drv0_data  = d0d;
  assign ifb.drv1_valid = d1v;
  assign ifb.drv1_data  = d1d;

  clocking_skew_if #(.WIDTH(8), .IN_STAGES(1), .OUT_STAGES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
  );
  clocking_skew_if #(.WIDTH(8), .IN_STAGES(2), .OUT_STAGES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
  );

  // Reference model: one entry per rising edge since reset release.
  logic [7:0] h_in  [$];
  bit         h_vld [$];
  logic [7:0] h_dat [$];
  int         m_coll;

  task automatic model_clear();
    h_in.delete();
    h_vld.delete();
    h_dat.delete();
    m_coll = 0;
  endtask

  task automatic tick();
    h_in.push_back(sig1);
    h_vld.push_back(d0v | d1v);
    h_dat.push_back(d1v ? d1d : d0d);
    if (d0v && d1v && m_coll < 255) m_coll++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_cb(int stages);
    if (h_in.size() >= stages) return h_in[h_in.size() - stages];
    return 8'h00;
  endfunction

  // Latest drive accepted at edge n with n + stages - 1 <= current edge.
  function automatic logic [7:0] exp_sig2(int stages);
    logic [7:0] r = 8'h00;
    for (int i = 0; i <= int'(h_vld.size()) - stages; i++)
      if (h_vld[i]) r = h_dat[i];
    return r;
  endfunction

  task automatic drives_off();
    d0v = 1'b0;
    d1v = 1'b0;
    d0d = 8'h00;
    d1d = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drives_off();
    sig1 = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    sig1 = 8'hFF;
    d0v = 1'b1;
    d0d = 8'hEE;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ifa.cb_sig1_input !== 8'h00 || ifb.cb_sig1_input !== 8'h00) begin
      $display("FAIL reset_cb: got a=%h b=%h expected 00", ifa.cb_sig1_input, ifb.cb_sig1_input);
    end else n_pass++;
    n_checks++;
    if (ifa.sig2_output !== 8'h00 || ifb.sig2_output !== 8'h00) begin
      $display("FAIL reset_sig2: got a=%h b=%h expected 00", ifa.sig2_output, ifb.sig2_output);
    end else n_pass++;
`ifdef CB_COLLISION_CNT_EN
    n_checks++;
    if (ifa.collision_cnt !== 8'h00) begin
      $display("FAIL reset_cnt: got %h expected 00", ifa.collision_cnt);
    end else n_pass++;
`endif
    do_reset();
  endtask

  task automatic test_sample();
    do_reset();
    sig1 = 8'h12;
    n_checks++;
    if (ifa.cb_sig1_input !== 8'h00) begin
      $display("FAIL sample_pre: got %h expected 00", ifa.cb_sig1_input);
    end else n_pass++;
    tick();
    n_checks++;
    if (ifa.cb_sig1_input !== 8'h12) begin
      $display("FAIL sample_e1: got %h expected 12", ifa.cb_sig1_input);
    end else n_pass++;
    sig1 = 8'h56;
    tick();
    n_checks++;
    if (ifa.cb_sig1_input !== 8'h56) begin
      $display("FAIL sample_e2: got %h expected 56", ifa.cb_sig1_input);
    end else n_pass++;
    n_checks++;
    if (ifb.cb_sig1_input !== exp_cb(2)) begin
      $display("FAIL sample_b_e2: got %h expected %h", ifb.cb_sig1_input, exp_cb(2));
    end else n_pass++;
  endtask

  task automatic test_sticky();
    do_reset();
    d0v = 1'b1;
    d0d = 8'h34;
    tick();
    drives_off();
    n_checks++;
    if (ifa.sig2_output !== 8'h34) begin
      $display("FAIL sticky_e1: got %h expected 34", ifa.sig2_output);
    end else n_pass++;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (ifa.sig2_output !== 8'h34) begin
        $display("FAIL sticky_hold%0d: got %h expected 34", k, ifa.sig2_output);
      end else n_pass++;
    end
  endtask

  task automatic test_collision();
    do_reset();
    d0v = 1'b1; d0d = 8'h78;
    d1v = 1'b1; d1d = 8'hAA;
    tick();
    n_checks++;
    if (ifa.sig2_output !== 8'hAA) begin
      $display("FAIL coll1_sig2: got %h expected AA", ifa.sig2_output);
    end else n_pass++;
`ifdef CB_COLLISION_CNT_EN
    n_checks++;
    if (ifa.collision_cnt !== 8'h01) begin
      $display("FAIL coll1_cnt: got %h expected 01", ifa.collision_cnt);
    end else n_pass++;
`endif
    d0d = 8'hBC;
    d1d = 8'hDD;
    tick();
    drives_off();
    n_checks++;
    if (ifa.sig2_output !== 8'hDD) begin
      $display("FAIL coll2_sig2: got %h expected DD", ifa.sig2_output);
    end else n_pass++;
`ifdef CB_COLLISION_CNT_EN
    n_checks++;
    if (ifa.collision_cnt !== 8'h02) begin
      $display("FAIL coll2_cnt: got %h expected 02", ifa.collision_cnt);
    end else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] want [5];
    want[0] = 8'h00; want[1] = 8'h00; want[2] = 8'h01; want[3] = 8'h02; want[4] = 8'h03;
    do_reset();
    for (int e = 0; e < 5; e++) begin
      if (e < 3) begin
        d0v = 1'b1;
        d0d = 8'(e + 1);
      end else begin
        drives_off();
      end
      tick();
      n_checks++;
      if (ifb.sig2_output !== want[e]) begin
        $display("FAIL b2b_edge%0d: got %h expected %h", e + 1, ifb.sig2_output, want[e]);
      end else n_pass++;
    end
  endtask

  task automatic test_flush();
    do_reset();
    d0v = 1'b1;
    d0d = 8'h5A;
    tick();
    drives_off();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ifb.sig2_output !== 8'h00) begin
      $display("FAIL flush_now: got %h expected 00", ifb.sig2_output);
    end else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (ifb.sig2_output !== 8'h00) begin
        $display("FAIL flush_edge%0d: got %h expected 00", k + 1, ifb.sig2_output);
      end else n_pass++;
    end
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int k = 0; k < 200; k++) begin
      sig1 = 8'($urandom);
      d0v  = ($urandom_range(0, 2) == 0);
      d0d  = 8'($urandom);
      d1v  = ($urandom_range(0, 3) == 0);
      d1d  = 8'($urandom);
      tick();
      n_checks++;
      if (ifa.cb_sig1_input !== exp_cb(1) || ifb.cb_sig1_input !== exp_cb(2)) begin
        $display("FAIL rand_cb@%0d: got a=%h b=%h expected a=%h b=%h", k,
                 ifa.cb_sig1_input, ifb.cb_sig1_input, exp_cb(1), exp_cb(2));
        errs++;
      end else n_pass++;
      n_checks++;
      if (ifa.sig2_output !== exp_sig2(1) || ifb.sig2_output !== exp_sig2(3)) begin
        $display("FAIL rand_sig2@%0d: got a=%h b=%h expected a=%h b=%h", k,
                 ifa.sig2_output, ifb.sig2_output, exp_sig2(1), exp_sig2(3));
        errs++;
      end else n_pass++;
`ifdef CB_COLLISION_CNT_EN
      n_checks++;
      if (ifa.collision_cnt !== 8'(m_coll)) begin
        $display("FAIL rand_cnt@%0d: got %h expected %h", k, ifa.collision_cnt, 8'(m_coll));
        errs++;
      end else n_pass++;
`endif
      if (errs > 10) break;
    end
    drives_off();
  endtask

  task automatic test_saturate();
`ifdef CB_COLLISION_CNT_EN
    do_reset();
    d0v = 1'b1; d0d = 8'h11;
    d1v = 1'b1; d1d = 8'h22;
    repeat (300) tick();
    drives_off();
    n_checks++;
    if (ifa.collision_cnt !== 8'hFF) begin
      $display("FAIL saturate_cnt: got %h expected FF", ifa.collision_cnt);
    end else n_pass++;
    n_checks++;
    if (ifb.collision_cnt !== 8'hFF) begin
      $display("FAIL saturate_cnt_b: got %h expected FF", ifb.collision_cnt);
    end else n_pass++;
`endif
  endtask

  initial begin
    model_clear();
    test_reset();
    test_sample();
    test_sticky();
    test_collision();
    test_back_to_back();
    test_flush();
    test_random();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
